// File: rtl/mul_pipe_arb_if.sv
// Bundle between mul_pipe_arb, its requesters/consumers and the external multiplier.
// The err signal exists only when MUL_ARB_CHECK_EN is defined.
interface mul_pipe_arb_if #(
  parameter int W    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [NREQ*2*W-1:0] resp_p;
  logic                mul_in_valid;
  logic [W-1:0]        mul_a;
  logic [W-1:0]        mul_b;
  logic                mul_out_valid;
  logic [2*W-1:0]      mul_p;
`ifdef MUL_ARB_CHECK_EN
  logic                err;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_out_valid, mul_p,
    output req_ready, resp_valid, resp_p, mul_in_valid, mul_a, mul_b, err
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_out_valid, mul_p,
    input  req_ready, resp_valid, resp_p, mul_in_valid, mul_a, mul_b, err
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mul_out_valid, mul_p,
    output req_ready, resp_valid, resp_p, mul_in_valid, mul_a, mul_b
  );
  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_out_valid, mul_p,
    input  req_ready, resp_valid, resp_p, mul_in_valid, mul_a, mul_b
  );
`endif
endinterface

// File: rtl/mul_pipe_arb.sv
// Round-robin sharing of one external pipelined multiplier among NREQ requesters,
// with credit-backed per-requester response FIFOs. Optional checker: MUL_ARB_CHECK_EN.
module mul_pipe_arb #(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 4
) (
  input logic           clk,
  input logic           rst_n,
  mul_pipe_arb_if.slave bus
);
  localparam int IW    = $clog2(NREQ);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PRODW = 2 * W;

  logic [CW-1:0]    cred_r   [NREQ];
  logic [IW-1:0]    rr_ptr_r;
  logic [NREQ-1:0]  grant_s;
  logic [IW-1:0]    gnt_idx_s;
  logic             gnt_any_s;
  int               idx_s;
  logic [MUL_LAT-1:0] tag_v_r;
  logic [IW-1:0]    tag_id_r [MUL_LAT];
  logic [PRODW-1:0] mem_r    [NREQ][DEPTH];
  logic [PW-1:0]    wptr_r   [NREQ];
  logic [PW-1:0]    rptr_r   [NREQ];
  logic [CW-1:0]    cnt_r    [NREQ];
  logic [NREQ-1:0]  push_s;
  logic [NREQ-1:0]  pop_s;
  logic [NREQ-1:0]  nonempty_s;

  // Round-robin pick of the first eligible requester at or after rr_ptr
  always_comb begin
    grant_s   = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NREQ;
      if (!gnt_any_s && bus.req_valid[idx_s] && (cred_r[idx_s] < CW'(DEPTH))) begin
        gnt_any_s      = 1'b1;
        gnt_idx_s      = IW'(idx_s);
        grant_s[idx_s] = 1'b1;
      end else begin
        grant_s[idx_s] = 1'b0;
      end
    end
  end

  assign bus.req_ready    = grant_s;
  assign bus.mul_in_valid = gnt_any_s;

  // Operand steering; idle cycles present zero operands
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    if (gnt_any_s) begin
      bus.mul_a = bus.req_a[gnt_idx_s*W +: W];
      bus.mul_b = bus.req_b[gnt_idx_s*W +: W];
    end else begin
      bus.mul_a = '0;
      bus.mul_b = '0;
    end
  end

  // Arbitration pointer and the {valid,id} tag pipeline matched to multiplier latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
      tag_v_r  <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_id_r[k] <= '0;
    end else begin
      if (gnt_any_s) begin
        rr_ptr_r <= (gnt_idx_s == IW'(NREQ - 1)) ? '0 : gnt_idx_s + IW'(1);
      end
      tag_v_r[0]  <= gnt_any_s;
      tag_id_r[0] <= gnt_idx_s;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Returning product is steered by the last-stage tag only
  always_comb begin
    push_s     = '0;
    nonempty_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      push_s[i]     = tag_v_r[MUL_LAT-1] && (tag_id_r[MUL_LAT-1] == IW'(i));
      nonempty_s[i] = (cnt_r[i] != '0);
    end
  end

  assign pop_s          = nonempty_s & bus.resp_ready;
  assign bus.resp_valid = nonempty_s;

  // Credit (in flight + buffered), FIFO pointers and occupancy per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        cred_r[i] <= '0;
        cnt_r[i]  <= '0;
        wptr_r[i] <= '0;
        rptr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant_s[i], pop_s[i]})
          2'b10:   cred_r[i] <= cred_r[i] + CW'(1);
          2'b01:   cred_r[i] <= cred_r[i] - CW'(1);
          default: cred_r[i] <= cred_r[i];
        endcase
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
        if (push_s[i]) wptr_r[i] <= (wptr_r[i] == PW'(DEPTH - 1)) ? '0 : wptr_r[i] + PW'(1);
        if (pop_s[i])  rptr_r[i] <= (rptr_r[i] == PW'(DEPTH - 1)) ? '0 : rptr_r[i] + PW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by occupancy so need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push_s[i]) mem_r[i][wptr_r[i]] <= bus.mul_p;
    end
  end

  // Head-of-FIFO products, forced to zero while empty
  always_comb begin
    bus.resp_p = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (nonempty_s[i]) begin
        bus.resp_p[i*PRODW +: PRODW] = mem_r[i][rptr_r[i]];
      end else begin
        bus.resp_p[i*PRODW +: PRODW] = '0;
      end
    end
  end

`ifdef MUL_ARB_CHECK_EN
  logic err_r;

  // Sticky flag: multiplier valid disagreed with the expected last-stage tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (bus.mul_out_valid != tag_v_r[MUL_LAT-1]) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`endif
endmodule
